mem_dump_reader: RTL and testbench
==================================

MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 8900, giving the first data-RAM word address in the processor map.
REQ-002 The block SHALL have parameter WORD_COUNT, default 129200, giving the number of words to read; legal range 1..2^20.
REQ-003 The block SHALL have parameter RD_LATENCY, default 1, giving the cycles from a mem_addr change to valid mem_rd; legal range 0..3.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have these ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-high
- start  input  1  single-cycle request to begin a dump
- mem_addr  output  32  word address driven into the memory controller address input
- mem_rd  input  32  read data returned by the memory controller
- out_data  output  32  word being presented downstream
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts out_data
- busy  output  1  a dump is in progress
- done  output  1  one-cycle pulse after the last word is accepted

Function
REQ-006 The block SHALL implement FSM states IDLE, ISSUE, WAIT, PRESENT, FINISH.
REQ-007 In IDLE, the block SHALL drive mem_addr=0 (the controller default region), out_valid=0 and busy=0.
REQ-008 In IDLE, when start=1, the block SHALL clear the word index idx to 0 and go to ISSUE on the next cycle.
REQ-009 In ISSUE, the block SHALL drive mem_addr=BASE_ADDR+idx and load the latency counter with RD_LATENCY.
- If RD_LATENCY=0, the block SHALL capture mem_rd in the same cycle and go to PRESENT.
- Otherwise, it SHALL go to WAIT.
REQ-010 In WAIT, the block SHALL hold mem_addr constant and decrement the latency counter each cycle.
- When the counter reaches 1, the block SHALL capture mem_rd into out_data on that edge and go to PRESENT.
- The total capture delay from the first ISSUE cycle SHALL be exactly RD_LATENCY cycles.
REQ-011 In PRESENT, the block SHALL assert out_valid=1 and hold out_data and mem_addr stable until out_ready=1.
REQ-012 In PRESENT with out_ready=1, the handshake completes that cycle.
- If idx=WORD_COUNT-1, the block SHALL go to FINISH.
- Otherwise, it SHALL increment idx and go to ISSUE.
REQ-013 out_valid SHALL NOT be deasserted in PRESENT before the handshake, and SHALL be 0 in every other state.
REQ-014 In FINISH, the block SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-015 busy SHALL be 1 in ISSUE, WAIT, PRESENT and FINISH.
REQ-016 start SHALL be ignored in every state except IDLE, including in FINISH.
REQ-017 mem_addr SHALL be computed as a 32-bit unsigned sum with no wrap.
- The block SHALL never drive an address at or above BASE_ADDR+WORD_COUNT.
- idx SHALL be 20 bits wide.
REQ-018 The block SHALL never write memory. It SHALL issue exactly one address per word, in strictly ascending order with no gaps or repeats.
REQ-019 out_ready held at 1 continuously SHALL give throughput of one word per RD_LATENCY+2 cycles. Minimum: 2 cycles per word when RD_LATENCY=0.

Reset
REQ-020 On reset=1 at a clock edge, the block SHALL enter IDLE with idx=0, out_data=0, out_valid=0, busy=0, done=0 and mem_addr=0.
REQ-021 Reset mid-dump SHALL abandon the dump with no done pulse.
- A start in the first cycle after reset deasserts SHALL begin a fresh dump at BASE_ADDR.
REQ-022 Reset SHALL take priority over start and out_ready in the same cycle.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Basic dump: WORD_COUNT=4, RD_LATENCY=1, memory model rd=addr*3, out_ready=1, pulse start -> out_data sequence 26700, 26703, 26706, 26709. One word every 3 cycles. done pulses once, 1 cycle after the 4th handshake. busy then falls.
- Back-pressure: out_ready=0 for 5 cycles while word 1 is presented -> out_valid stays 1, and out_data and mem_addr=8901 stay stable. No address advance until out_ready=1.
- Latency sweep: RD_LATENCY=0 and RD_LATENCY=3 with WORD_COUNT=3 -> each word equals the model value for its own address. Spacing is 2 and 5 cycles respectively.
- Ignored start: pulse start during WAIT and during FINISH -> no restart, idx not reset, exactly one done.
- Reset mid-dump: assert reset in PRESENT of word 2 -> next cycle all outputs 0, no done. A new start reads from 8900 again.
- Single word: WORD_COUNT=1 -> one handshake at 8900, then done. mem_addr never reaches 8901.

Source files
------------

// File: rtl/mem_dump_reader.sv
// Streams WORD_COUNT words from a read-only data RAM, starting at BASE_ADDR, to a valid/ready sink.
// Latency: RD_LATENCY+2 cycles per word (ISSUE, RD_LATENCY x WAIT, PRESENT); done one cycle after the last handshake.
// Backpressure: holds out_data and mem_addr stable in PRESENT until out_ready; no new address is issued meanwhile.
module mem_dump_reader #(
  parameter int unsigned BASE_ADDR  = 8900,
  parameter int unsigned WORD_COUNT = 129200,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] PRESENT = 3'd3;
  localparam logic [2:0] FINISH  = 3'd4;

  // Index of the final word; WORD_COUNT tops out at 2^20 so this always fits in 20 bits.
  localparam logic [19:0] LAST_IDX = 20'(WORD_COUNT - 1);
  localparam logic [1:0]  LAT      = 2'(RD_LATENCY);
  localparam logic [31:0] BASE     = 32'(BASE_ADDR);

  logic [2:0]  state;
  logic [19:0] idx;
  logic [1:0]  lat_cnt;
  logic [31:0] data_q;
  logic [31:0] word_addr;

  // Address of the word currently being fetched or presented.
  assign word_addr = BASE + {12'd0, idx};

  // Main sequencer: issue one address, wait out the read latency, present, repeat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= 20'd0;
      lat_cnt <= 2'd0;
      data_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= 20'd0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          lat_cnt <= LAT;
          if (LAT == 2'd0) begin
            // Combinational memory: read data is already valid for this address.
            data_q <= mem_rd;
            state  <= PRESENT;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // Counter value 1 marks the cycle in which mem_rd becomes valid.
          lat_cnt <= lat_cnt - 2'd1;
          if (lat_cnt == 2'd1) begin
            data_q <= mem_rd;
            state  <= PRESENT;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              state <= FINISH;
            end else begin
              idx   <= idx + 20'd1;
              state <= ISSUE;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode directly from registered state, so they are glitch-free relative to the clock edge.
  // The address bus parks at 0 outside an active fetch, which also keeps it below the dump's upper bound.
  assign mem_addr  = ((state == ISSUE) || (state == WAIT) || (state == PRESENT)) ? word_addr : 32'd0;
  assign out_data  = data_q;
  assign out_valid = (state == PRESENT);
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: four instances cover WORD_COUNT/RD_LATENCY combinations,
// each fed by a memory model returning addr*3 after that instance's read latency.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_dump_reader;

  logic clk;
  logic rst [4];
  logic st  [4];
  logic rdy [4];
  logic [31:0] rd [4];

  logic [31:0] addr0, addr1, addr2, addr3;
  logic [31:0] data0, data1, data2, data3;
  logic val0, val1, val2, val3;
  logic busy0, busy1, busy2, busy3;
  logic done0, done1, done2, done3;

  logic [31:0] addr_v [4];
  logic [31:0] data_v [4];
  logic        val_v  [4];
  logic        busy_v [4];
  logic        done_v [4];

  logic [31:0] p1 [4];
  logic [31:0] p2 [4];
  logic [31:0] p3 [4];

  int cyc = 0;
  int n_tot = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          off;
  } hs_row_t;

  hs_row_t tbl [11];
  int first_row [4];
  int num_rows  [4];
  int done_off  [4];

  logic [31:0] hs_addr [$];
  logic [31:0] hs_data [$];
  int          hs_cyc  [$];
  int          ndone;
  int          done_cyc;
  logic        busy_after;
  logic [31:0] max_addr;

  mem_dump_reader #(.BASE_ADDR(8900), .WORD_COUNT(4), .RD_LATENCY(1)) u0 (
    .clk(clk), .reset(rst[0]), .start(st[0]), .mem_addr(addr0), .mem_rd(rd[0]),
    .out_data(data0), .out_valid(val0), .out_ready(rdy[0]), .busy(busy0), .done(done0));
  mem_dump_reader #(.BASE_ADDR(8900), .WORD_COUNT(3), .RD_LATENCY(0)) u1 (
    .clk(clk), .reset(rst[1]), .start(st[1]), .mem_addr(addr1), .mem_rd(rd[1]),
    .out_data(data1), .out_valid(val1), .out_ready(rdy[1]), .busy(busy1), .done(done1));
  mem_dump_reader #(.BASE_ADDR(8900), .WORD_COUNT(3), .RD_LATENCY(3)) u2 (
    .clk(clk), .reset(rst[2]), .start(st[2]), .mem_addr(addr2), .mem_rd(rd[2]),
    .out_data(data2), .out_valid(val2), .out_ready(rdy[2]), .busy(busy2), .done(done2));
  mem_dump_reader #(.BASE_ADDR(8900), .WORD_COUNT(1), .RD_LATENCY(1)) u3 (
    .clk(clk), .reset(rst[3]), .start(st[3]), .mem_addr(addr3), .mem_rd(rd[3]),
    .out_data(data3), .out_valid(val3), .out_ready(rdy[3]), .busy(busy3), .done(done3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to time handshakes.
  always @(posedge clk) cyc <= cyc + 1;

  // Gather instance outputs into arrays so tasks can address an instance by number.
  always_comb begin
    addr_v[0] = addr0; addr_v[1] = addr1; addr_v[2] = addr2; addr_v[3] = addr3;
    data_v[0] = data0; data_v[1] = data1; data_v[2] = data2; data_v[3] = data3;
    val_v[0]  = val0;  val_v[1]  = val1;  val_v[2]  = val2;  val_v[3]  = val3;
    busy_v[0] = busy0; busy_v[1] = busy1; busy_v[2] = busy2; busy_v[3] = busy3;
    done_v[0] = done0; done_v[1] = done1; done_v[2] = done2; done_v[3] = done3;
  end

  // Memory model: read data is addr*3, delayed by the instance's read latency.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      p1[i] <= addr_v[i] * 32'd3;
      p2[i] <= p1[i];
      p3[i] <= p2[i];
    end
  end
  assign rd[0] = p1[0];
  assign rd[1] = addr1 * 32'd3;
  assign rd[2] = p3[2];
  assign rd[3] = p1[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input int i, input bit check);
    rst[i] = 1'b1; st[i] = 1'b0; rdy[i] = 1'b0;
    tick(); tick();
    if (check) begin
      chk("reset_addr", addr_v[i], 32'd0);
      chk("reset_data", data_v[i], 32'd0);
      chk("reset_valid", {31'd0, val_v[i]}, 32'd0);
      chk("reset_busy", {31'd0, busy_v[i]}, 32'd0);
      chk("reset_done", {31'd0, done_v[i]}, 32'd0);
    end
    rst[i] = 1'b0;
  endtask

  task automatic pulse_start(input int i);
    st[i] = 1'b1;
    tick();
    st[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, input string nm);
    int k = 0;
    while (!val_v[i] && k < 20) begin
      tick();
      k++;
    end
    chk(nm, {31'd0, val_v[i]}, 32'd1);
  endtask

  task automatic accept(input int i);
    rdy[i] = 1'b1;
    tick();
    rdy[i] = 1'b0;
  endtask

  // Run n cycles recording handshakes, done pulses and the highest address seen.
  task automatic collect(input int i, input int n, input bit start_on_done);
    bit prev_done = 1'b0;
    hs_addr.delete(); hs_data.delete(); hs_cyc.delete();
    ndone = 0; done_cyc = -1; busy_after = 1'b1; max_addr = 32'd0;
    repeat (n) begin
      if (val_v[i] && rdy[i]) begin
        hs_addr.push_back(addr_v[i]);
        hs_data.push_back(data_v[i]);
        hs_cyc.push_back(cyc);
      end
      if (addr_v[i] > max_addr) max_addr = addr_v[i];
      if (prev_done) busy_after = busy_v[i];
      if (done_v[i]) begin
        ndone++;
        done_cyc = cyc;
        if (start_on_done) st[i] = 1'b1;
      end
      prev_done = done_v[i];
      tick();
      st[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] hs_a(input int r);
    return (r < hs_addr.size()) ? hs_addr[r] : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] hs_d(input int r);
    return (r < hs_data.size()) ? hs_data[r] : 32'hFFFF_FFFF;
  endfunction

  // Full dump with out_ready held high, compared against the vector table.
  task automatic run_table(input int i);
    int base;
    do_reset(i, 1'b0);
    rdy[i] = 1'b1;
    base = cyc;
    pulse_start(i);
    collect(i, 30, 1'b0);
    chk($sformatf("i%0d_hs_count", i), 32'(hs_addr.size()), 32'(num_rows[i]));
    for (int r = 0; r < num_rows[i]; r++) begin
      chk($sformatf("i%0d_w%0d_addr", i, r), hs_a(r), tbl[first_row[i] + r].addr);
      chk($sformatf("i%0d_w%0d_data", i, r), hs_d(r), tbl[first_row[i] + r].data);
      chk($sformatf("i%0d_w%0d_cycle", i, r),
          (r < hs_cyc.size()) ? 32'(hs_cyc[r] - base) : 32'hFFFF_FFFF,
          32'(tbl[first_row[i] + r].off));
    end
    chk($sformatf("i%0d_done_count", i), 32'(ndone), 32'd1);
    chk($sformatf("i%0d_done_cycle", i), 32'(done_cyc - base), 32'(done_off[i]));
    chk($sformatf("i%0d_busy_after_done", i), {31'd0, busy_after}, 32'd0);
    chk($sformatf("i%0d_max_addr", i), max_addr, 32'd8899 + 32'(num_rows[i]));
    rdy[i] = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{32'd8900, 32'd26700, 3};
    tbl[1]  = '{32'd8901, 32'd26703, 6};
    tbl[2]  = '{32'd8902, 32'd26706, 9};
    tbl[3]  = '{32'd8903, 32'd26709, 12};
    tbl[4]  = '{32'd8900, 32'd26700, 2};
    tbl[5]  = '{32'd8901, 32'd26703, 4};
    tbl[6]  = '{32'd8902, 32'd26706, 6};
    tbl[7]  = '{32'd8900, 32'd26700, 5};
    tbl[8]  = '{32'd8901, 32'd26703, 10};
    tbl[9]  = '{32'd8902, 32'd26706, 15};
    tbl[10] = '{32'd8900, 32'd26700, 3};
    first_row = '{0, 4, 7, 10};
    num_rows  = '{4, 3, 3, 1};
    done_off  = '{13, 7, 16, 4};

    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; st[i] = 1'b0; rdy[i] = 1'b0;
    end
    tick();

    // Reset state, then table-driven dumps for every latency/length combination.
    do_reset(0, 1'b1);
    for (int i = 0; i < 4; i++) run_table(i);

    // Back-pressure: hold word 1 for five cycles.
    do_reset(0, 1'b0);
    pulse_start(0);
    wait_valid(0, "bp_w0_valid");
    chk("bp_w0_addr", addr_v[0], 32'd8900);
    chk("bp_w0_data", data_v[0], 32'd26700);
    accept(0);
    wait_valid(0, "bp_w1_valid");
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp_hold%0d_valid", k), {31'd0, val_v[0]}, 32'd1);
      chk($sformatf("bp_hold%0d_addr", k), addr_v[0], 32'd8901);
      chk($sformatf("bp_hold%0d_data", k), data_v[0], 32'd26703);
    end
    accept(0);
    chk("bp_next_addr", addr_v[0], 32'd8902);
    chk("bp_next_valid", {31'd0, val_v[0]}, 32'd0);
    rdy[0] = 1'b1;
    collect(0, 20, 1'b0);
    chk("bp_rest_count", 32'(hs_addr.size()), 32'd2);
    chk("bp_rest_addr", hs_a(1), 32'd8903);
    chk("bp_done_count", 32'(ndone), 32'd1);

    // Start pulses in WAIT and in FINISH are ignored.
    do_reset(0, 1'b0);
    rdy[0] = 1'b1;
    pulse_start(0);
    tick();
    pulse_start(0);
    collect(0, 20, 1'b1);
    chk("ign_hs_count", 32'(hs_addr.size()), 32'd4);
    for (int r = 0; r < 4; r++)
      chk($sformatf("ign_w%0d_addr", r), hs_a(r), 32'd8900 + 32'(r));
    chk("ign_done_count", 32'(ndone), 32'd1);
    chk("ign_busy_end", {31'd0, busy_v[0]}, 32'd0);

    // Reset while word 2 is presented, then an immediate fresh start.
    do_reset(0, 1'b0);
    pulse_start(0);
    wait_valid(0, "mid_w0_valid");
    accept(0);
    wait_valid(0, "mid_w1_valid");
    accept(0);
    wait_valid(0, "mid_w2_valid");
    chk("mid_w2_addr", addr_v[0], 32'd8902);
    rst[0] = 1'b1;
    tick();
    chk("mid_rst_addr", addr_v[0], 32'd0);
    chk("mid_rst_data", data_v[0], 32'd0);
    chk("mid_rst_valid", {31'd0, val_v[0]}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("mid_rst_done", {31'd0, done_v[0]}, 32'd0);
    rst[0] = 1'b0;
    rdy[0] = 1'b1;
    pulse_start(0);
    collect(0, 20, 1'b0);
    chk("mid_restart_count", 32'(hs_addr.size()), 32'd4);
    chk("mid_restart_addr", hs_a(0), 32'd8900);
    chk("mid_restart_data", hs_d(0), 32'd26700);
    chk("mid_restart_done", 32'(ndone), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
